// File: rtl/blt_cmd_decode.sv
// Bluetooth command decoder: assembles HDR/CMD/CHK frames from UART byte strobes and
// drives registered direction, pause and restart controls for the snake game logic.
module blt_cmd_decode #(
    parameter int unsigned TIMEOUT = 5_000_000,
    parameter logic [7:0]  HDR     = 8'hA5,
    parameter logic [7:0]  CHK_KEY = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ack,
    input  logic [7:0] data_in,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       pause,
    output logic       restart,
    output logic       frame_err
);

    localparam int unsigned      CNT_W    = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [7:0] CMD_UP      = 8'h01;
    localparam logic [7:0] CMD_DOWN    = 8'h02;
    localparam logic [7:0] CMD_LEFT    = 8'h03;
    localparam logic [7:0] CMD_RIGHT   = 8'h04;
    localparam logic [7:0] CMD_PAUSE   = 8'h10;
    localparam logic [7:0] CMD_RESTART = 8'h20;
    localparam logic [1:0] DIR_RIGHT   = 2'b11;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_CMD = 2'd1,
        S_CHK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             timeout_c;
    logic [1:0]       req_dir_c;

    logic [1:0] dir_d;
    logic       dir_valid_d, pause_d, restart_d, frame_err_d;

    // An ack landing on the expiry cycle takes priority over the timeout
    assign timeout_c = (state_q != S_HDR) && !ack && (cnt_q == CNT_LAST);
    assign cnt_d     = (state_q == S_HDR || ack || timeout_c) ? '0 : cnt_q + CNT_W'(1);
    // Movement commands 01..04 map onto direction codes 00..11
    assign req_dir_c = cmd_q[1:0] - 2'b01;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            S_HDR: begin
                if (ack && data_in == HDR) state_d = S_CMD;
            end
            S_CMD: begin
                if (ack) begin
                    cmd_d   = data_in;
                    state_d = S_CHK;
                end else if (timeout_c) begin
                    state_d = S_HDR;
                end
            end
            S_CHK: begin
                if (ack || timeout_c) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    // Output logic: next values of the registered controls
    always_comb begin
        dir_d       = dir;
        pause_d     = pause;
        dir_valid_d = 1'b0;
        restart_d   = 1'b0;
        frame_err_d = timeout_c;
        if (ack && state_q == S_CHK) begin
            if (data_in != (cmd_q ^ CHK_KEY)) begin
                frame_err_d = 1'b1;
            end else begin
                case (cmd_q)
                    CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT: begin
                        // Reverse of the current heading differs only in bit 0
                        if (!pause && req_dir_c != dir && req_dir_c != (dir ^ 2'b01)) begin
                            dir_d       = req_dir_c;
                            dir_valid_d = 1'b1;
                        end
                    end
                    CMD_PAUSE: pause_d = ~pause;
                    CMD_RESTART: begin
                        restart_d = 1'b1;
                        pause_d   = 1'b0;
                        dir_d     = DIR_RIGHT;
                    end
                    default: frame_err_d = 1'b1;
                endcase
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir       <= DIR_RIGHT;
            dir_valid <= 1'b0;
            pause     <= 1'b0;
            restart   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            dir       <= dir_d;
            dir_valid <= dir_valid_d;
            pause     <= pause_d;
            restart   <= restart_d;
            frame_err <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_blt_cmd_decode.sv
// Directed bench for blt_cmd_decode: frame-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_blt_cmd_decode;

    localparam int unsigned TIMEOUT = 20;
    localparam logic [7:0]  HDR     = 8'hA5;
    localparam logic [7:0]  KEY     = 8'h5A;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] dir;
    logic       dir_valid, pause, restart, frame_err;

    int errors = 0;
    int checks = 0;

    blt_cmd_decode #(
        .TIMEOUT (TIMEOUT),
        .HDR     (HDR),
        .CHK_KEY (KEY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ack       (ack),
        .data_in   (data_in),
        .dir       (dir),
        .dir_valid (dir_valid),
        .pause     (pause),
        .restart   (restart),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes collected into a frame list, idle cycles counted since last byte
    logic [7:0] frame_q[$];
    int         idle = 0;
    logic [1:0] m_dir = 2'b11;
    logic       m_valid = 1'b0, m_pause = 1'b0, m_restart = 1'b0, m_err = 1'b0;

    task automatic apply(input logic [7:0] cmd, input logic [7:0] chk);
        int want;
        if ((cmd ^ KEY) != chk) begin
            m_err = 1'b1;
        end else if (cmd >= 8'h01 && cmd <= 8'h04) begin
            want = int'(cmd) - 1;   // 0 up, 1 down, 2 left, 3 right
            // same axis (want/2 equal) means either same heading or a U-turn
            if (!m_pause && (want / 2) != (int'(m_dir) / 2)) begin
                m_dir   = 2'(want);
                m_valid = 1'b1;
            end
        end else if (cmd == 8'h10) begin
            m_pause = !m_pause;
        end else if (cmd == 8'h20) begin
            m_restart = 1'b1;
            m_pause   = 1'b0;
            m_dir     = 2'b11;
        end else begin
            m_err = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q.delete();
            idle      = 0;
            m_dir     = 2'b11;
            m_valid   = 1'b0;
            m_pause   = 1'b0;
            m_restart = 1'b0;
            m_err     = 1'b0;
        end else begin
            m_valid   = 1'b0;
            m_restart = 1'b0;
            m_err     = 1'b0;
            if (ack) begin
                idle = 0;
                if (frame_q.size() != 0 || data_in == HDR) frame_q.push_back(data_in);
                if (frame_q.size() == 3) begin
                    apply(frame_q[1], frame_q[2]);
                    frame_q.delete();
                end
            end else if (frame_q.size() != 0) begin
                idle++;
                if (idle >= int'(TIMEOUT)) begin
                    m_err = 1'b1;
                    frame_q.delete();
                    idle = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_dir",       32'(dir),       32'(m_dir));
        check("cyc_dir_valid", 32'(dir_valid), 32'(m_valid));
        check("cyc_pause",     32'(pause),     32'(m_pause));
        check("cyc_restart",   32'(restart),   32'(m_restart));
        check("cyc_frame_err", 32'(frame_err), 32'(m_err));
    end

    // Driver: queued bytes go out on consecutive cycles, one ack each
    logic [7:0] txq[$];

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        txq.push_back(a);
        txq.push_back(b);
        txq.push_back(c);
    endtask

    task automatic flush();
        while (txq.size() != 0) begin
            @(posedge clk);
            #1;
            ack     = 1'b1;
            data_in = txq.pop_front();
        end
        @(posedge clk);
        #1;
        ack     = 1'b0;
        data_in = HDR;   // header value without a strobe must be ignored
    endtask

    task automatic send_byte(input logic [7:0] b);
        txq.push_back(b);
        flush();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3;
        check("rst_dir",   32'(dir),       32'h3);
        check("rst_valid", 32'(dir_valid), 32'h0);
        check("rst_pause", 32'(pause),     32'h0);
        check("rst_err",   32'(frame_err), 32'h0);
        rst = 1'b1;

        push3(8'hA5, 8'h01, 8'h5B); flush();
        check("t1_dir",   32'(dir),       32'h0);
        check("t1_valid", 32'(dir_valid), 32'h1);
        check("t1_err",   32'(frame_err), 32'h0);
        @(posedge clk); #1;
        check("t1_valid_once", 32'(dir_valid), 32'h0);

        push3(8'hA5, 8'h02, 8'h58); flush();
        check("t2_rev_dir",   32'(dir),       32'h0);
        check("t2_rev_valid", 32'(dir_valid), 32'h0);
        check("t2_rev_err",   32'(frame_err), 32'h0);
        push3(8'hA5, 8'h03, 8'h59); flush();
        check("t2_left_dir",   32'(dir),       32'h2);
        check("t2_left_valid", 32'(dir_valid), 32'h1);

        // two frames back to back
        push3(8'hA5, 8'h10, 8'h4A); push3(8'hA5, 8'h04, 8'h5E); flush();
        check("t3_pause",       32'(pause),     32'h1);
        check("t3_paused_dir",  32'(dir),       32'h2);
        check("t3_paused_vld",  32'(dir_valid), 32'h0);
        push3(8'hA5, 8'h20, 8'h7A); flush();
        check("t3_restart",     32'(restart),   32'h1);
        check("t3_rs_pause",    32'(pause),     32'h0);
        check("t3_rs_dir",      32'(dir),       32'h3);
        check("t3_rs_valid",    32'(dir_valid), 32'h0);

        push3(8'hA5, 8'h01, 8'h00); flush();
        check("t4_chk_err", 32'(frame_err), 32'h1);
        check("t4_chk_dir", 32'(dir),       32'h3);
        push3(8'hA5, 8'h77, 8'h2D); flush();
        check("t4_unk_err", 32'(frame_err), 32'h1);

        send_byte(8'hA5);
        repeat (19) @(posedge clk);
        #1;
        check("t5_before_expiry", 32'(frame_err), 32'h0);
        @(posedge clk); #1;
        check("t5_expiry", 32'(frame_err), 32'h1);
        repeat (5) @(posedge clk);
        push3(8'hA5, 8'h01, 8'h5B); flush();
        check("t5_after_dir",   32'(dir),       32'h0);
        check("t5_after_valid", 32'(dir_valid), 32'h1);

        send_byte(8'hA5);
        repeat (18) @(posedge clk);
        send_byte(8'h03);   // strobe sampled on the expiry edge
        check("t5_ack_wins_err", 32'(frame_err), 32'h0);
        send_byte(8'h59);
        check("t5_ack_wins_dir",   32'(dir),       32'h2);
        check("t5_ack_wins_valid", 32'(dir_valid), 32'h1);

        push3(8'hA5, 8'h02, 8'h58); flush();
        check("t6_down_dir", 32'(dir), 32'h1);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        check("t6_noise_err", 32'(frame_err), 32'h0);
        push3(8'hA5, 8'h03, 8'h59); flush();
        check("t6_dir",   32'(dir),       32'h2);
        check("t6_valid", 32'(dir_valid), 32'h1);
        check("t6_err",   32'(frame_err), 32'h0);

        push3(8'hA5, 8'h10, 8'h4A); flush();
        check("t6_pause_on", 32'(pause), 32'h1);
        send_byte(8'hA5);
        send_byte(8'h01);
        #5 rst = 1'b0;
        #2;
        check("t6_rst_dir",   32'(dir),   32'h3);
        check("t6_rst_pause", 32'(pause), 32'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        send_byte(8'h5B);   // stale checksum byte of the aborted frame
        check("t6_stale_dir", 32'(dir),       32'h3);
        check("t6_stale_err", 32'(frame_err), 32'h0);
        push3(8'hA5, 8'h01, 8'h5B); flush();
        check("t6_post_dir",   32'(dir),       32'h0);
        check("t6_post_valid", 32'(dir_valid), 32'h1);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
